// File: rtl/rr_reg_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter: FSM state
// encodings and the sizing rule for the owner/pointer fields.
package rr_reg_arbiter_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam int MIN_OWNER_W = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A single requester still needs one bit to hold its index.
    function automatic int owner_width(input int n);
        return (clog2(n) < MIN_OWNER_W) ? MIN_OWNER_W : clog2(n);
    endfunction

endpackage

// File: rtl/rr_reg_arbiter_shared_reg_w.sv
// W-bit edge-triggered D register with load enable and asynchronous
// active-low reset; drives both true and complemented outputs.
module shared_reg_w
    import rr_reg_arbiter_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_qb
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q  = r_q;
    assign o_qb = ~r_q;

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters,
// with an optional per-requester lock that keeps ownership across writes.
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int           N       = 4,
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [N-1:0]                                req,
    input  logic [N-1:0]                                lock,
    input  logic [N*W-1:0]                              wdata,
    output logic [N-1:0]                                gnt,
    output logic                                        ack,
    output logic [rr_reg_arbiter_pkg::owner_width(N)-1:0] owner,
    output logic [W-1:0]                                q,
    output logic [W-1:0]                                qb
);

    localparam int OW = owner_width(N);

    state_t          r_state;
    state_t          w_nextState;
    logic [OW-1:0]   r_ptr;
    logic [OW-1:0]   w_nextPtr;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_nextOwner;
    logic            r_ack;
    logic            w_nextAck;

    logic            w_lockHit;
    logic [OW-1:0]   w_basePtr;
    logic            w_grantValid;
    logic [OW-1:0]   w_grantIdx;
    logic [OW-1:0]   w_scanIdx;
    int              w_scan;
    logic [W-1:0]    w_selData;

    // Explicit wrap so non-power-of-two N never lands on an unused index.
    function automatic logic [OW-1:0] incWrap(input logic [OW-1:0] idx);
        if (int'(idx) >= N - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // A locked owner that stops requesting releases the lock in the same
    // cycle, so the scan starts just past it with no bubble.
    always_comb begin
        w_lockHit    = (r_state == ST_LOCK) && req[r_owner];
        w_basePtr    = (r_state == ST_LOCK) ? incWrap(r_owner) : r_ptr;
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_scan       = 0;
        w_scanIdx    = '0;
        if (w_lockHit) begin
            w_grantValid = 1'b1;
            w_grantIdx   = r_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                w_scan = int'(w_basePtr) + k;
                if (w_scan >= N) begin
                    w_scan = w_scan - N;
                end
                w_scanIdx = OW'(w_scan);
                if (!w_grantValid && req[w_scanIdx]) begin
                    w_grantValid = 1'b1;
                    w_grantIdx   = w_scanIdx;
                end
            end
        end
    end

    always_comb begin
        gnt       = '0;
        w_selData = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grantIdx == OW'(i)) begin
                w_selData = wdata[i*W +: W];
                gnt[i]    = rst && w_grantValid;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_ptr;
        w_nextOwner = r_owner;
        w_nextAck   = 1'b0;
        if (w_grantValid) begin
            w_nextAck   = 1'b1;
            w_nextOwner = w_grantIdx;
            if (lock[w_grantIdx]) begin
                w_nextState = ST_LOCK;
                w_nextPtr   = w_basePtr;
            end else begin
                w_nextState = ST_ARB;
                w_nextPtr   = incWrap(w_grantIdx);
            end
        end else begin
            w_nextState = ST_ARB;
            w_nextPtr   = w_basePtr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_ARB;
            r_ptr   <= '0;
            r_owner <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_ptr   <= w_nextPtr;
            r_owner <= w_nextOwner;
            r_ack   <= w_nextAck;
        end
    end

    shared_reg_w #(
        .W       (W),
        .RST_VAL (RST_VAL)
    ) u_reg (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_grantValid),
        .i_d     (w_selData),
        .o_q     (q),
        .o_qb    (qb)
    );

    assign ack   = r_ack;
    assign owner = r_owner;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scenario-driven bench for rr_reg_arbiter: expected writes are queued
// when a grant is driven and retired when the register updates.
module tb_rr_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        ack;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic [7:0]  qb;

    typedef struct {
        logic [7:0] q;
        logic [1:0] owner;
    } exp_t;

    exp_t       sb[$];
    int         nCompared   = 0;
    int         nMismatched = 0;
    logic [7:0] lastQ       = 8'h00;

    rr_reg_arbiter #(.N(4), .W(8), .RST_VAL(8'h00)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .owner (owner),
        .q     (q),
        .qb    (qb)
    );

    always #5 clk = ~clk;

    // Drives one cycle of stimulus; grant is sampled mid-cycle, registered
    // outputs 1 ns after the edge that ends the cycle.
    task automatic step(input logic [3:0] r, input logic [3:0] l, output logic [3:0] g,
                        output logic a, output logic [7:0] qv, output logic [7:0] qbv,
                        output logic [1:0] ov);
        req  = r;
        lock = l;
        #1 g = gnt;
        @(posedge clk);
        #1;
        a   = ack;
        qv  = q;
        qbv = qb;
        ov  = owner;
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        #2 rst = 1'b1;
        sb.delete();
        lastQ = 8'h00;
    endtask

    task automatic test_reset();
        logic [3:0] g; logic a; logic [7:0] qv, qbv; logic [1:0] ov; exp_t e;
        req  = 4'b1111;
        lock = 4'b0000;
        #2 rst = 1'b0;
        #1;
        nCompared++; if (q !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_q got %h want 00", q); end
        nCompared++; if (qb !== 8'hFF) begin nMismatched++; $display("[TB] FAIL reset_qb got %h want ff", qb); end
        nCompared++; if (gnt !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_gnt got %b want 0000", gnt); end
        nCompared++; if (ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ack got %b want 0", ack); end
        #2 rst = 1'b1;
        sb.delete();
        sb.push_back('{8'h10, 2'd0});
        step(4'b1111, 4'b0000, g, a, qv, qbv, ov);
        nCompared++; if (g !== 4'b0001) begin nMismatched++; $display("[TB] FAIL reset_first_gnt got %b want 0001", g); end
        if (sb.size() == 0) begin nCompared++; nMismatched++; $display("[TB] FAIL reset_sb empty"); end
        else begin
            e = sb.pop_front(); lastQ = e.q;
            nCompared++; if (a !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_first_ack got %b want 1", a); end
            nCompared++; if (qv !== e.q) begin nMismatched++; $display("[TB] FAIL reset_first_q got %h want %h", qv, e.q); end
            nCompared++; if (ov !== e.owner) begin nMismatched++; $display("[TB] FAIL reset_first_owner got %0d want %0d", ov, e.owner); end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] g; logic a; logic [7:0] qv, qbv; logic [1:0] ov; exp_t e;
        logic [3:0] expG [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] expO [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{8'h10 + 8'(expO[i]), expO[i]});
            step(4'b1111, 4'b0000, g, a, qv, qbv, ov);
            nCompared++; if (g !== expG[i]) begin nMismatched++; $display("[TB] FAIL rot_gnt[%0d] got %b want %b", i, g, expG[i]); end
            e = sb.pop_front(); lastQ = e.q;
            nCompared++; if (a !== 1'b1) begin nMismatched++; $display("[TB] FAIL rot_ack[%0d] got %b want 1", i, a); end
            nCompared++; if (qv !== e.q) begin nMismatched++; $display("[TB] FAIL rot_q[%0d] got %h want %h", i, qv, e.q); end
            nCompared++; if (qbv !== ~e.q) begin nMismatched++; $display("[TB] FAIL rot_qb[%0d] got %h want %h", i, qbv, ~e.q); end
            nCompared++; if (ov !== e.owner) begin nMismatched++; $display("[TB] FAIL rot_owner[%0d] got %0d want %0d", i, ov, e.owner); end
        end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] g; logic a; logic [7:0] qv, qbv; logic [1:0] ov; exp_t e;
        logic [3:0] reqs [3] = '{4'b0100, 4'b0011, 4'b0011};
        logic [3:0] expG [3] = '{4'b0100, 4'b0001, 4'b0010};
        logic [1:0] expO [3] = '{2'd2, 2'd0, 2'd1};
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{8'h10 + 8'(expO[i]), expO[i]});
            step(reqs[i], 4'b0000, g, a, qv, qbv, ov);
            nCompared++; if (g !== expG[i]) begin nMismatched++; $display("[TB] FAIL wrap_gnt[%0d] got %b want %b", i, g, expG[i]); end
            e = sb.pop_front(); lastQ = e.q;
            nCompared++; if (qv !== e.q) begin nMismatched++; $display("[TB] FAIL wrap_q[%0d] got %h want %h", i, qv, e.q); end
            nCompared++; if (ov !== e.owner) begin nMismatched++; $display("[TB] FAIL wrap_owner[%0d] got %0d want %0d", i, ov, e.owner); end
        end
    endtask

    task automatic test_lock();
        logic [3:0] g; logic a; logic [7:0] qv, qbv; logic [1:0] ov; exp_t e;
        logic [3:0] locks [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic [3:0] expG  [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        logic [7:0] expQ  [5] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h12};
        logic [1:0] expO  [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        pulseReset();
        wdata[15:8] = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{expQ[i], expO[i]});
            step(4'b0110, locks[i], g, a, qv, qbv, ov);
            nCompared++; if (g !== expG[i]) begin nMismatched++; $display("[TB] FAIL lock_gnt[%0d] got %b want %b", i, g, expG[i]); end
            e = sb.pop_front(); lastQ = e.q;
            nCompared++; if (a !== 1'b1) begin nMismatched++; $display("[TB] FAIL lock_ack[%0d] got %b want 1", i, a); end
            nCompared++; if (qv !== e.q) begin nMismatched++; $display("[TB] FAIL lock_q[%0d] got %h want %h", i, qv, e.q); end
            nCompared++; if (ov !== e.owner) begin nMismatched++; $display("[TB] FAIL lock_owner[%0d] got %0d want %0d", i, ov, e.owner); end
        end
    endtask

    task automatic test_lock_drop();
        logic [3:0] g; logic a; logic [7:0] qv, qbv; logic [1:0] ov; exp_t e;
        logic [3:0] reqs [2] = '{4'b0110, 4'b0100};
        logic [3:0] expG [2] = '{4'b0010, 4'b0100};
        logic [7:0] expQ [2] = '{8'hA5, 8'h12};
        logic [1:0] expO [2] = '{2'd1, 2'd2};
        pulseReset();
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{expQ[i], expO[i]});
            step(reqs[i], 4'b0010, g, a, qv, qbv, ov);
            nCompared++; if (g !== expG[i]) begin nMismatched++; $display("[TB] FAIL drop_gnt[%0d] got %b want %b", i, g, expG[i]); end
            e = sb.pop_front(); lastQ = e.q;
            nCompared++; if (a !== 1'b1) begin nMismatched++; $display("[TB] FAIL drop_ack[%0d] got %b want 1", i, a); end
            nCompared++; if (qv !== e.q) begin nMismatched++; $display("[TB] FAIL drop_q[%0d] got %h want %h", i, qv, e.q); end
            nCompared++; if (ov !== e.owner) begin nMismatched++; $display("[TB] FAIL drop_owner[%0d] got %0d want %0d", i, ov, e.owner); end
        end
        wdata[15:8] = 8'h11;
    endtask

    task automatic test_idle_reset_mid_lock();
        logic [3:0] g; logic a; logic [7:0] qv, qbv; logic [1:0] ov; exp_t e;
        for (int i = 0; i < 2; i++) begin
            step(4'b0000, 4'b0000, g, a, qv, qbv, ov);
            nCompared++; if (g !== 4'b0000) begin nMismatched++; $display("[TB] FAIL idle_gnt[%0d] got %b want 0000", i, g); end
            nCompared++; if (a !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_ack[%0d] got %b want 0", i, a); end
            nCompared++; if (qv !== lastQ) begin nMismatched++; $display("[TB] FAIL idle_q[%0d] got %h want %h", i, qv, lastQ); end
            nCompared++; if (qbv !== ~lastQ) begin nMismatched++; $display("[TB] FAIL idle_qb[%0d] got %h want %h", i, qbv, ~lastQ); end
        end
        sb.push_back('{8'h13, 2'd3});
        step(4'b1000, 4'b1000, g, a, qv, qbv, ov);
        nCompared++; if (g !== 4'b1000) begin nMismatched++; $display("[TB] FAIL mlock_gnt got %b want 1000", g); end
        e = sb.pop_front(); lastQ = e.q;
        nCompared++; if (qv !== e.q) begin nMismatched++; $display("[TB] FAIL mlock_q got %h want %h", qv, e.q); end
        nCompared++; if (ov !== e.owner) begin nMismatched++; $display("[TB] FAIL mlock_owner got %0d want %0d", ov, e.owner); end
        #2 rst = 1'b0;
        #1;
        nCompared++; if (owner !== 2'd0) begin nMismatched++; $display("[TB] FAIL mrst_owner got %0d want 0", owner); end
        nCompared++; if (q !== 8'h00) begin nMismatched++; $display("[TB] FAIL mrst_q got %h want 00", q); end
        nCompared++; if (ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL mrst_ack got %b want 0", ack); end
        nCompared++; if (gnt !== 4'b0000) begin nMismatched++; $display("[TB] FAIL mrst_gnt got %b want 0000", gnt); end
        #2 rst = 1'b1;
        sb.delete();
        sb.push_back('{8'h10, 2'd0});
        step(4'b1001, 4'b0000, g, a, qv, qbv, ov);
        nCompared++; if (g !== 4'b0001) begin nMismatched++; $display("[TB] FAIL mrst_first_gnt got %b want 0001", g); end
        e = sb.pop_front(); lastQ = e.q;
        nCompared++; if (qv !== e.q) begin nMismatched++; $display("[TB] FAIL mrst_first_q got %h want %h", qv, e.q); end
        nCompared++; if (ov !== e.owner) begin nMismatched++; $display("[TB] FAIL mrst_first_owner got %0d want %0d", ov, e.owner); end
    endtask

    initial begin
        rst   = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        #12 rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_rotation();
        test_wrap_skip();
        test_lock();
        test_lock_drop();
        test_idle_reset_mid_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
Round-robin arbiter that shares one W-bit storage register between N requesters.
- Each cycle it picks at most one requester and loads that requester's data into the register on the next rising clk edge.
- Optional per-requester lock holds ownership across consecutive writes.
- Sits in front of the team's edge-triggered D-register and drives q/qb to downstream logic.

Parameters:
- N, 4, number of requesters (2..16; need not be a power of two).
- W, 8, register data width.
- RST_VAL, 0, W-bit value loaded into q during reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (rst=0 resets immediately, independent of clk)
- req  input  N  request; bit i = requester i wants to write
- lock  input  N  bit i = requester i wants to keep ownership after this write
- wdata  input  N*W  requester i data at bits [i*W +: W]
- gnt  output  N  combinational one-hot grant; all-zero when nothing is granted
- ack  output  1  registered; 1 for one cycle after a write, meaning q now holds the new data
- owner  output  $clog2(N) (minimum 1)  registered index of the last writer
- q  output  W  register contents
- qb  output  W  always ~q

Behaviour:
- Reset (rst=0, async):
  - q=RST_VAL, qb=~RST_VAL, ack=0, owner=0.
  - Priority pointer ptr=0, state=ARB.
  - gnt=0 while rst=0.
  - Reset asserted mid-lock abandons the lock; the first cycle after release is normal ARB with ptr=0.
- State ARB:
  - gnt selects the first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping N-1 to 0.
  - No req: gnt=0, q holds, ptr holds, ack=0 next cycle.
- Write on the edge following grant of requester i:
  - q<=wdata[i], ack<=1, owner<=i.
  - If lock[i]=1: state<=LOCKED, ptr holds.
  - Else: ptr<=(i+1) mod N, with explicit wrap for non-power-of-two N.
- State LOCKED (owner = locked requester o):
  - req[o]=1: gnt=one-hot(o) regardless of other requests; write as above.
  - After that write: if lock[o]=0, state<=ARB and ptr<=(o+1) mod N; else stay LOCKED.
  - req[o]=0: lock is released in the same cycle. The block behaves as ARB with ptr=(o+1) mod N, so there is no bubble cycle. state<=ARB.
- Latency: grant and data selection in cycle t; q, ack and owner update at the edge ending cycle t. One cycle request-to-q.
- Back-to-back writes every cycle are allowed; ack stays 1 while writes continue.
- Fairness: in ARB, any continuously requesting requester is granted within N grants.
- q changes only on a granted edge or on reset; qb never differs from ~q.
- A lock bit with req=0 is ignored.

Decomposition:
- Shared include file holds:
  - State encodings ST_ARB=1'b0, ST_LOCK=1'b1.
  - A clog2 constant function.
  - The rule for owner/ptr width (minimum 1 bit).
- Sub-module shared_reg_w: W-bit D register with load enable, async active-low reset to RST_VAL, outputs q/qb.
- The arbiter FSM, pointer and mux stay in rr_reg_arbiter.

Test Plan:
1. Reset: drive rst=0 for 3 ns mid-cycle with req=4'b1111 → q=8'h00, qb=8'hFF, gnt=0, ack=0 immediately, without waiting for clk; the first grant after release goes to requester 0.
2. Rotation: req=4'b1111, wdata[i]=8'h10+i, lock=0, 5 cycles → gnt=0001,0010,0100,1000,0001; q=8'h10,11,12,13,10 one cycle after each grant; ack=1 throughout.
3. Wrap and skip: ptr=3 (after granting 2), req=4'b0011 → gnt=0001 then 0010; owner=0 then 1.
4. Lock: req=4'b0110, lock[1]=1 for 3 cycles, wdata[1]=8'hA5 → gnt=0010 three times. Then lock[1]=0 → one final grant to 1, then gnt=0100; q=8'hA5 until requester 2 writes.
5. Lock release by dropping req: in LOCKED with o=1, req 4'b0110→4'b0100 → gnt=0100 in that same cycle; no idle cycle.
6. Idle and reset mid-lock: req=0 for 2 cycles → q holds, ack=0. Then lock requester 3 and assert rst=0 → state ARB, owner=0, q=RST_VAL; after release, req=4'b1001 grants 0 first.
